// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary quadrature generator and decoder.
// Provides the FSM state type, the 2-bit phase index width and the
// left/right Gray-order quadrature tables indexed by phase ({A,B}).
package rotary_pkg;

    localparam int unsigned PHASE_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Quadrature pair packed as {A,B}
    typedef logic [1:0] ab_t;

    // Left: A rises while B = 1
    localparam ab_t LEFT_SEQ [4]  = '{2'b00, 2'b01, 2'b11, 2'b10};
    // Right: A rises while B = 0
    localparam ab_t RIGHT_SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Table lookup for a given direction and phase index
    function automatic ab_t quad_seq(input logic left, input logic [PHASE_IDX_W-1:0] idx);
        return left ? LEFT_SEQ[idx] : RIGHT_SEQ[idx];
    endfunction

endpackage

// File: rtl/rotary_quadrature_gen_if.sv
// Command and status bundle of the rotary quadrature generator.
//   master: drives the command (valid/left/steps/abort), observes status.
//   slave : the generator; drives ready, A/B, busy, done, steps_left.
interface rotary_quadrature_gen_if #(
    parameter int unsigned STEP_W = 8
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_left;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_abort;
    logic              rotary_A;
    logic              rotary_B;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_left;

    modport master (
        output cmd_valid, cmd_left, cmd_steps, cmd_abort,
        input  cmd_ready, rotary_A, rotary_B, busy, done, steps_left
    );

    modport slave (
        input  cmd_valid, cmd_left, cmd_steps, cmd_abort,
        output cmd_ready, rotary_A, rotary_B, busy, done, steps_left
    );

endinterface

// File: rtl/rotary_phase_timer.sv
// Phase dwell timer: counts 0..PHASE_CYCLES-1 while enabled and raises a
// registered one-cycle wrap pulse during the last count of each phase.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : hold count at 0 (synchronous)
//   enable_i   : advance the count
//   wrap_o     : high in the cycle whose closing edge ends the phase
module rotary_phase_timer #(
    parameter int unsigned PHASE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic wrap_o
);

    localparam int unsigned CNT_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
    // Wrap is registered one count early so it lines up with CNT_LAST
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PHASE_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    // Count and wrap state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    // Next count / wrap
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            wrap_d = (cnt_q == CNT_PRE);
        end
    end

    assign wrap_o = wrap_q;

endmodule

// File: rtl/rotary_quadrature_gen.sv
// Rotary quadrature generator: emits cmd_steps full quadrature cycles on
// A/B in the commanded direction, each state held PHASE_CYCLES clocks.
//   clk, rst_n : clock, async active-low reset
//   bus_if     : command handshake (valid/ready/left/steps/abort) and
//                status (rotary_A/B, busy, done pulse, steps_left)
module rotary_quadrature_gen
    import rotary_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 4,
    parameter int unsigned STEP_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rotary_quadrature_gen_if.slave bus_if
);

    state_e                 state_q, state_d;
    logic [PHASE_IDX_W-1:0] phase_q, phase_d;
    logic [STEP_W-1:0]      steps_q, steps_d;
    logic                   left_q, left_d;
    logic                   abort_q, abort_d;
    ab_t                    ab_q, ab_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   accept_c;
    logic                   timer_clear_c;
    logic                   timer_en_c;
    logic                   wrap;

    // ready_q is only ever high while IDLE, so it alone qualifies accept
    assign accept_c      = bus_if.cmd_valid && ready_q;
    assign timer_clear_c = (state_q != RUN);
    assign timer_en_c    = (state_q == RUN);

    rotary_phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (timer_clear_c),
        .enable_i (timer_en_c),
        .wrap_o   (wrap)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            steps_q <= '0;
            left_q  <= 1'b0;
            abort_q <= 1'b0;
            ab_q    <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            steps_q <= steps_d;
            left_q  <= left_d;
            abort_q <= abort_d;
            ab_q    <= ab_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, step counter and output decode
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        steps_d = steps_q;
        left_d  = left_q;
        abort_d = abort_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    left_d  = bus_if.cmd_left;
                    steps_d = bus_if.cmd_steps;
                    abort_d = 1'b0;
                    phase_d = '0;
                    state_d = (bus_if.cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus_if.cmd_abort) begin
                    abort_d = 1'b1;
                end
                if (wrap) begin
                    phase_d = phase_q + PHASE_IDX_W'(1);
                    // Last phase of a step: back at 00, one detent finished
                    if (phase_q == PHASE_IDX_W'(3)) begin
                        steps_d = steps_q - STEP_W'(1);
                        if ((steps_q == STEP_W'(1)) || abort_d) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ab_d    = (state_d == RUN) ? quad_seq(left_d, phase_d) : ab_t'(0);
        busy_d  = (state_d == RUN);
        // done/ready trail the DONE state by one cycle each
        done_d  = (state_q == DONE);
        ready_d = (state_q == IDLE) && (state_d == IDLE);
    end

    assign bus_if.cmd_ready  = ready_q;
    assign bus_if.rotary_A   = ab_q[1];
    assign bus_if.rotary_B   = ab_q[0];
    assign bus_if.busy       = busy_q;
    assign bus_if.done       = done_q;
    assign bus_if.steps_left = steps_q;

endmodule

// File: tb/tb_rotary_quadrature_gen.sv
// Directed bench for rotary_quadrature_gen with a loop-back quadrature
// event counter standing in for the decoder.
module tb_rotary_quadrature_gen;

    localparam int unsigned PC     = 4;
    localparam int unsigned STEP_W = 8;

    logic clk;
    logic rst_n;

    rotary_quadrature_gen_if #(.STEP_W(STEP_W)) bus ();

    rotary_quadrature_gen #(
        .PHASE_CYCLES (PC),
        .STEP_W       (STEP_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0] left_tbl  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] right_tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Loop-back decoder: one event per A rising edge, left when B = 1
    int   ev_cnt  = 0;
    int   ev_left = 0;
    logic a_prev  = 1'b0;
    always @(negedge clk) begin
        if (bus.rotary_A && !a_prev) begin
            ev_cnt <= ev_cnt + 1;
            if (bus.rotary_B) ev_left <= ev_left + 1;
        end
        a_prev <= bus.rotary_A;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ab_now();
        return {bus.rotary_A, bus.rotary_B};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command (steps >= 1) and check every transition and the
    // done/ready timing. With keep_valid, a different command stays on
    // the bus during RUN and must not disturb the running one.
    task automatic run_cmd(input logic left, input int steps, input logic keep_valid);
        int         guard;
        int         ev0;
        int         evl0;
        logic [1:0] prev;
        logic [1:0] exp;
        guard = 0;
        while (!bus.cmd_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("ready_before_accept", 32'(bus.cmd_ready), 32'd1);
        ev0  = ev_cnt;
        evl0 = ev_left;
        bus.cmd_valid = 1'b1;
        bus.cmd_left  = left;
        bus.cmd_steps = STEP_W'(steps);
        tick();
        if (keep_valid) begin
            bus.cmd_left  = ~left;
            bus.cmd_steps = STEP_W'(steps + 5);
        end else begin
            bus.cmd_valid = 1'b0;
        end
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        chk("ready_after_accept", 32'(bus.cmd_ready), 32'd0);
        chk("steps_left_load", 32'(bus.steps_left), 32'(steps));
        chk("ab_at_accept", 32'(ab_now()), 32'd0);
        prev = 2'b00;
        for (int k = 1; k <= 4 * steps; k++) begin
            repeat (PC - 1) tick();
            chk("ab_hold", 32'(ab_now()), 32'(prev));
            tick();
            exp = left ? left_tbl[k % 4] : right_tbl[k % 4];
            chk("ab_transition", 32'(ab_now()), 32'(exp));
            if (k % 4 == 0) chk("steps_left_dec", 32'(bus.steps_left), 32'(steps - k / 4));
            prev = exp;
        end
        chk("busy_end", 32'(bus.busy), 32'd0);
        chk("done_early", 32'(bus.done), 32'd0);
        tick();
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("ready_during_done", 32'(bus.cmd_ready), 32'd0);
        chk("ab_in_done", 32'(ab_now()), 32'd0);
        tick();
        chk("done_width", 32'(bus.done), 32'd0);
        chk("ready_return", 32'(bus.cmd_ready), 32'd1);
        chk("dec_events", 32'(ev_cnt - ev0), 32'(steps));
        chk("dec_left", 32'(ev_left - evl0), left ? 32'(steps) : 32'd0);
    endtask

    initial begin
        int guard;
        bus.cmd_valid = 1'b0;
        bus.cmd_left  = 1'b0;
        bus.cmd_steps = '0;
        bus.cmd_abort = 1'b0;
        rst_n = 1'b0;

        // Reset state
        #12;
        chk("rst_ab", 32'(ab_now()), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_steps_left", 32'(bus.steps_left), 32'd0);
        #8;
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);

        // Left 2 steps, right 3 steps
        run_cmd(1'b1, 2, 1'b0);
        run_cmd(1'b0, 3, 1'b0);

        // Zero steps: done next cycle, no activity on A/B
        bus.cmd_valid = 1'b1;
        bus.cmd_left  = 1'b1;
        bus.cmd_steps = '0;
        tick();
        bus.cmd_valid = 1'b0;
        chk("zero_busy_T", 32'(bus.busy), 32'd0);
        chk("zero_ready_T", 32'(bus.cmd_ready), 32'd0);
        chk("zero_done_T", 32'(bus.done), 32'd0);
        tick();
        chk("zero_done_T1", 32'(bus.done), 32'd1);
        chk("zero_busy_T1", 32'(bus.busy), 32'd0);
        chk("zero_ab_T1", 32'(ab_now()), 32'd0);
        chk("zero_ready_T1", 32'(bus.cmd_ready), 32'd0);
        tick();
        chk("zero_done_T2", 32'(bus.done), 32'd0);
        chk("zero_ready_T2", 32'(bus.cmd_ready), 32'd1);

        // Abort at T+6 of a 5-step left command
        bus.cmd_valid = 1'b1;
        bus.cmd_left  = 1'b1;
        bus.cmd_steps = 8'd5;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (5) tick();
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        chk("abort_ab_T6", 32'(ab_now()), 32'b01);
        repeat (9) tick();
        chk("abort_ab_T15", 32'(ab_now()), 32'b10);
        chk("abort_busy_T15", 32'(bus.busy), 32'd1);
        tick();
        chk("abort_ab_T16", 32'(ab_now()), 32'd0);
        chk("abort_steps_T16", 32'(bus.steps_left), 32'd4);
        chk("abort_busy_T16", 32'(bus.busy), 32'd0);
        tick();
        chk("abort_done_T17", 32'(bus.done), 32'd1);
        chk("abort_steps_T17", 32'(bus.steps_left), 32'd4);
        tick();
        chk("abort_done_T18", 32'(bus.done), 32'd0);
        chk("abort_ready_T18", 32'(bus.cmd_ready), 32'd1);
        chk("abort_steps_T18", 32'(bus.steps_left), 32'd4);

        // Abort in IDLE is ignored
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        chk("idle_abort_ready", 32'(bus.cmd_ready), 32'd1);
        chk("idle_abort_done", 32'(bus.done), 32'd0);

        // Asynchronous reset mid-step
        bus.cmd_valid = 1'b1;
        bus.cmd_left  = 1'b0;
        bus.cmd_steps = 8'd3;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (10) tick();
        chk("pre_reset_ab", 32'(ab_now()), 32'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ab", 32'(ab_now()), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_steps", 32'(bus.steps_left), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        run_cmd(1'b1, 1, 1'b0);

        // cmd_valid held with new values during RUN
        run_cmd(1'b0, 2, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("second_accept_busy", 32'(bus.busy), 32'd1);
        chk("second_accept_steps", 32'(bus.steps_left), 32'd7);
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        repeat (3) tick();
        chk("second_dir_left", 32'(ab_now()), 32'b01);
        guard = 0;
        while (!bus.done && guard < 40) begin
            tick();
            guard++;
        end
        chk("second_done_seen", 32'(bus.done), 32'd1);
        chk("second_steps_left", 32'(bus.steps_left), 32'd6);
        chk("second_ab", 32'(ab_now()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
